// File: rtl/mlp_feature_sequencer.sv
// -----------------------------------------------------------------------------
// mlp_feature_sequencer
//
// Front-end feeder for a fully combinational printed-MLP classifier. ADC
// samples arrive one feature at a time on a valid/ready stream. Each sample is
// reduced to FEAT_W bits and packed into the classifier's flat input vector.
// The completed vector is held stable for SETTLE_CYC cycles. The classifier's
// class index is then captured and presented on a valid/ready result port.
//
// Optional build macro:
//   MLP_SEQ_RND_EN - round-half-up feature reduction with saturation at
//                    all-ones (only when ADC_W > FEAT_W). When the macro is
//                    undefined, the reduction is plain truncation.
//
// Ports:
//   clk      in   single clock
//   rst_n    in   asynchronous active-low reset
//   s_valid  in   sample valid
//   s_ready  out  sample ready (high whenever collecting)
//   s_data   in   ADC sample, ADC_W bits
//   s_sof    in   start-of-frame marker, qualified by s_valid
//   mlp_inp  out  packed features, feature i at [i*FEAT_W +: FEAT_W]
//   mlp_cls  in   classifier argmax, combinational from mlp_inp
//   m_valid  out  result valid
//   m_ready  in   result ready
//   m_cls    out  captured class index
//   sof_err  out  one-cycle pulse: frame restarted by s_sof before completion
//
// State table:
//   state   | meaning
//   COLLECT | accepting samples into slots 0..N_FEAT-1
//   SETTLE  | mlp_inp frozen, waiting for the classifier to settle
//   PRESENT | result held on m_valid/m_cls until m_ready
// -----------------------------------------------------------------------------
module mlp_feature_sequencer #(
    parameter int N_FEAT     = 6,
    parameter int FEAT_W     = 4,
    parameter int ADC_W      = 8,
    parameter int CLS_W      = 2,
    parameter int SETTLE_CYC = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     s_valid,
    output logic                     s_ready,
    input  logic [ADC_W-1:0]         s_data,
    input  logic                     s_sof,
    output logic [N_FEAT*FEAT_W-1:0] mlp_inp,
    input  logic [CLS_W-1:0]         mlp_cls,
    output logic                     m_valid,
    input  logic                     m_ready,
    output logic [CLS_W-1:0]         m_cls,
    output logic                     sof_err
);

    localparam int IDX_W = (N_FEAT > 1) ? $clog2(N_FEAT) : 1;
    localparam int CNT_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_FEAT - 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(SETTLE_CYC - 1);

    typedef enum logic [1:0] {
        COLLECT = 2'd0,
        SETTLE  = 2'd1,
        PRESENT = 2'd2
    } state_t;

    state_t           state;
    logic [IDX_W-1:0] idx;
    logic [CNT_W-1:0] cnt;

    logic [FEAT_W-1:0] feat_trunc;
    logic [FEAT_W-1:0] feat;
    logic              restart;
    logic [IDX_W-1:0]  widx;
    logic              unused_bits;

    assign feat_trunc  = s_data[ADC_W-1 -: FEAT_W];
    // The low sample bits are intentionally dropped in the truncating build.
    assign unused_bits = ^s_data;

`ifdef MLP_SEQ_RND_EN
    generate
        if (ADC_W > FEAT_W) begin : g_rnd
            logic [FEAT_W:0] sum;
            assign sum  = {1'b0, feat_trunc} + {{FEAT_W{1'b0}}, s_data[ADC_W-FEAT_W-1]};
            // A carry out of the top bit means we would wrap; clamp instead.
            assign feat = sum[FEAT_W] ? {FEAT_W{1'b1}} : sum[FEAT_W-1:0];
        end else begin : g_pass
            assign feat = feat_trunc;
        end
    endgenerate
`else
    assign feat = feat_trunc;
`endif

    assign s_ready = (state == COLLECT);

    // A start-of-frame in the middle of a frame discards what was collected
    // so far and writes this sample to slot 0.
    assign restart = s_sof && (idx != '0);
    assign widx    = restart ? '0 : idx;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= COLLECT;
            idx     <= '0;
            cnt     <= '0;
            mlp_inp <= '0;
            m_cls   <= '0;
            m_valid <= 1'b0;
            sof_err <= 1'b0;
        end else begin
            sof_err <= 1'b0;
            case (state)
                COLLECT: begin
                    if (s_valid) begin
                        mlp_inp[int'(widx)*FEAT_W +: FEAT_W] <= feat;
                        sof_err <= restart;
                        if (widx == LAST_IDX) begin
                            idx   <= '0;
                            cnt   <= '0;
                            state <= SETTLE;
                        end else begin
                            idx <= widx + 1'b1;
                        end
                    end
                end
                SETTLE: begin
                    if (cnt == LAST_CNT) begin
                        m_cls   <= mlp_cls;
                        m_valid <= 1'b1;
                        state   <= PRESENT;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                PRESENT: begin
                    if (m_ready) begin
                        m_valid <= 1'b0;
                        state   <= COLLECT;
                    end
                end
                default: state <= COLLECT;
            endcase
        end
    end

endmodule

// File: tb/tb_mlp_feature_sequencer.sv
// -----------------------------------------------------------------------------
// tb_mlp_feature_sequencer
//
// Directed bench for mlp_feature_sequencer at default parameters. A table of
// per-sample records drives three frames, and each sample's slot value and
// sof_err are checked. A shared task checks settle latency, the result hold
// under backpressure and the handshake at the end of every frame. A
// hand-written sequence covers reset asserted during SETTLE.
// -----------------------------------------------------------------------------
module tb_mlp_feature_sequencer;

    localparam int N_FEAT     = 6;
    localparam int FEAT_W     = 4;
    localparam int ADC_W      = 8;
    localparam int CLS_W      = 2;
    localparam int SETTLE_CYC = 2;

`ifdef MLP_SEQ_RND_EN
    localparam logic [3:0]  R78   = 4'h8;
    localparam logic [3:0]  R0F   = 4'h1;
    localparam logic [23:0] C_INP = 24'h6541F8;
`else
    localparam logic [3:0]  R78   = 4'h7;
    localparam logic [3:0]  R0F   = 4'h0;
    localparam logic [23:0] C_INP = 24'h6540F7;
`endif

    logic                     clk = 1'b0;
    logic                     rst_n = 1'b0;
    logic                     s_valid = 1'b0;
    logic                     s_ready;
    logic [ADC_W-1:0]         s_data = '0;
    logic                     s_sof = 1'b0;
    logic [N_FEAT*FEAT_W-1:0] mlp_inp;
    logic [CLS_W-1:0]         mlp_cls = '0;
    logic                     m_valid;
    logic                     m_ready = 1'b0;
    logic [CLS_W-1:0]         m_cls;
    logic                     sof_err;

    mlp_feature_sequencer #(
        .N_FEAT(N_FEAT), .FEAT_W(FEAT_W), .ADC_W(ADC_W),
        .CLS_W(CLS_W), .SETTLE_CYC(SETTLE_CYC)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_sof(s_sof),
        .mlp_inp(mlp_inp), .mlp_cls(mlp_cls),
        .m_valid(m_valid), .m_ready(m_ready), .m_cls(m_cls),
        .sof_err(sof_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  data;
        logic        sof;
        int          slot;
        logic [3:0]  feat;
        logic        err;
        logic        last;
        logic [23:0] exp_inp;
        logic [1:0]  cls;
    } vec_t;

    vec_t vecs[21];
    int   n_tot  = 0;
    int   n_pass = 0;

    function automatic vec_t mk(input logic [7:0] d, input logic sof, input int slot,
                                input logic [3:0] f, input logic err, input logic last,
                                input logic [23:0] inp, input logic [1:0] cls);
        vec_t v;
        v.data = d; v.sof = sof; v.slot = slot; v.feat = f; v.err = err;
        v.last = last; v.exp_inp = inp; v.cls = cls;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    // Called #1 after a posedge; returns #1 after the accepting posedge.
    task automatic send(input logic [7:0] d, input logic sof);
        s_valid = 1'b1;
        s_data  = d;
        s_sof   = sof;
        chk("s_ready_collect", 32'(s_ready), 32'd1);
        @(posedge clk); #1;
        s_valid = 1'b0;
        s_sof   = 1'b0;
    endtask

    // Called #1 after the edge that accepted the last feature of a frame.
    task automatic finish_frame(input logic [23:0] exp_inp, input logic [1:0] cls);
        mlp_cls = cls;
        chk("s_ready_settle", 32'(s_ready), 32'd0);
        chk("m_valid_settle0", 32'(m_valid), 32'd0);
        for (int k = 1; k < SETTLE_CYC; k++) begin
            @(posedge clk); #1;
            chk("m_valid_settle", 32'(m_valid), 32'd0);
        end
        @(posedge clk); #1;
        chk("m_valid_rise", 32'(m_valid), 32'd1);
        chk("m_cls_capture", 32'(m_cls), 32'(cls));
        chk("mlp_inp_frame", 32'(mlp_inp), 32'(exp_inp));
        // Backpressure with competing samples and a changing classifier output.
        s_valid = 1'b1;
        s_data  = 8'hFF;
        s_sof   = 1'b1;
        mlp_cls = ~cls;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            chk("s_ready_present", 32'(s_ready), 32'd0);
            chk("m_valid_hold", 32'(m_valid), 32'd1);
            chk("m_cls_hold", 32'(m_cls), 32'(cls));
            chk("mlp_inp_hold", 32'(mlp_inp), 32'(exp_inp));
            chk("sof_err_present", 32'(sof_err), 32'd0);
        end
        s_valid = 1'b0;
        s_sof   = 1'b0;
        m_ready = 1'b1;
        @(posedge clk); #1;
        m_ready = 1'b0;
        chk("m_valid_drop", 32'(m_valid), 32'd0);
        chk("s_ready_after", 32'(s_ready), 32'd1);
        chk("m_cls_retain", 32'(m_cls), 32'(cls));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        // Frame A: plain frame, s_sof on the first sample (no error).
        vecs[0]  = mk(8'h10, 1'b1, 0, 4'h1, 1'b0, 1'b0, 24'h0, 2'b00);
        vecs[1]  = mk(8'h20, 1'b0, 1, 4'h2, 1'b0, 1'b0, 24'h0, 2'b00);
        vecs[2]  = mk(8'h30, 1'b0, 2, 4'h3, 1'b0, 1'b0, 24'h0, 2'b00);
        vecs[3]  = mk(8'h40, 1'b0, 3, 4'h4, 1'b0, 1'b0, 24'h0, 2'b00);
        vecs[4]  = mk(8'h50, 1'b0, 4, 4'h5, 1'b0, 1'b0, 24'h0, 2'b00);
        vecs[5]  = mk(8'h60, 1'b0, 5, 4'h6, 1'b0, 1'b1, 24'h654321, 2'b10);
        // Frame B: restart by s_sof after three samples.
        vecs[6]  = mk(8'h11, 1'b1, 0, 4'h1, 1'b0, 1'b0, 24'h0, 2'b00);
        vecs[7]  = mk(8'h22, 1'b0, 1, 4'h2, 1'b0, 1'b0, 24'h0, 2'b00);
        vecs[8]  = mk(8'h33, 1'b0, 2, 4'h3, 1'b0, 1'b0, 24'h0, 2'b00);
        vecs[9]  = mk(8'hF0, 1'b1, 0, 4'hF, 1'b1, 1'b0, 24'h0, 2'b00);
        vecs[10] = mk(8'hA0, 1'b0, 1, 4'hA, 1'b0, 1'b0, 24'h0, 2'b00);
        vecs[11] = mk(8'hB0, 1'b0, 2, 4'hB, 1'b0, 1'b0, 24'h0, 2'b00);
        vecs[12] = mk(8'hC0, 1'b0, 3, 4'hC, 1'b0, 1'b0, 24'h0, 2'b00);
        vecs[13] = mk(8'hD0, 1'b0, 4, 4'hD, 1'b0, 1'b0, 24'h0, 2'b00);
        vecs[14] = mk(8'hE0, 1'b0, 5, 4'hE, 1'b0, 1'b1, 24'hEDCBAF, 2'b01);
        // Frame C: reduction corner cases (rounding and saturation).
        vecs[15] = mk(8'h78, 1'b1, 0, R78,  1'b0, 1'b0, 24'h0, 2'b00);
        vecs[16] = mk(8'hF8, 1'b0, 1, 4'hF, 1'b0, 1'b0, 24'h0, 2'b00);
        vecs[17] = mk(8'h0F, 1'b0, 2, R0F,  1'b0, 1'b0, 24'h0, 2'b00);
        vecs[18] = mk(8'h40, 1'b0, 3, 4'h4, 1'b0, 1'b0, 24'h0, 2'b00);
        vecs[19] = mk(8'h50, 1'b0, 4, 4'h5, 1'b0, 1'b0, 24'h0, 2'b00);
        vecs[20] = mk(8'h60, 1'b0, 5, 4'h6, 1'b0, 1'b1, C_INP, 2'b11);

        // Reset state, with s_ready already high during reset.
        rst_n = 1'b0;
        #2;
        chk("s_ready_in_reset", 32'(s_ready), 32'd1);
        repeat (2) @(posedge clk);
        #1;
        chk("rst_m_valid", 32'(m_valid), 32'd0);
        chk("rst_mlp_inp", 32'(mlp_inp), 32'd0);
        chk("rst_m_cls", 32'(m_cls), 32'd0);
        chk("rst_sof_err", 32'(sof_err), 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 21; i++) begin
            send(vecs[i].data, vecs[i].sof);
            chk($sformatf("slot_v%0d", i), 32'(mlp_inp[vecs[i].slot*FEAT_W +: FEAT_W]),
                32'(vecs[i].feat));
            chk($sformatf("sof_err_v%0d", i), 32'(sof_err), 32'(vecs[i].err));
            if (vecs[i].last) finish_frame(vecs[i].exp_inp, vecs[i].cls);
        end

        // Reset asserted during SETTLE drops the pending frame and result.
        send(8'h90, 1'b1);
        for (int k = 1; k < N_FEAT; k++) send(8'h90, 1'b0);
        chk("settle_entered", 32'(s_ready), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        chk("midrst_m_valid", 32'(m_valid), 32'd0);
        chk("midrst_mlp_inp", 32'(mlp_inp), 32'd0);
        chk("midrst_s_ready", 32'(s_ready), 32'd1);
        chk("midrst_m_cls", 32'(m_cls), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        for (int i = 0; i < 6; i++) begin
            send(vecs[i].data, vecs[i].sof);
            chk($sformatf("post_rst_slot%0d", i),
                32'(mlp_inp[vecs[i].slot*FEAT_W +: FEAT_W]), 32'(vecs[i].feat));
        end
        finish_frame(24'h654321, 2'b10);

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
